// File: rtl/nnrv_dmem.sv
// Data-memory responder: byte-masked word RAM with zero-latency reads, plus an IO window
// holding a console TX FIFO and a 64-bit cycle counter with a latched high-half snapshot.
module nnrv_dmem #(
    parameter int         XLEN        = 32,
    parameter int         DEPTH_WORDS = 1024,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [3:0] IO_NIBBLE   = 4'h1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ram_rd_en,
    input  logic [XLEN-1:0] i_ram_rd_addr,
    input  logic [3:0]      i_ram_rd_mask,
    output logic [XLEN-1:0] o_ram_rd_data,
    input  logic            i_ram_wr_en,
    input  logic [XLEN-1:0] i_ram_wr_addr,
    input  logic [3:0]      i_ram_wr_mask,
    input  logic [XLEN-1:0] i_ram_wr_data,
    output logic            o_tx_valid,
    output logic [7:0]      o_tx_data,
    input  logic            i_tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_CYC_LO = 2'd2,
        REG_CYC_HI = 2'd3
    } io_reg_t;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [63:0]     cycle;
    logic [31:0]     hi_shadow;

    logic            rd_io, wr_io;
    logic [AW-1:0]   rd_idx, wr_idx;
    io_reg_t         rd_reg, wr_reg;
    logic            empty, full, push_req, push, pop, ovf_set, ovf_clr;
    logic            unused_bits;

    assign rd_io  = (i_ram_rd_addr[XLEN-1 -: 4] == IO_NIBBLE);
    assign wr_io  = (i_ram_wr_addr[XLEN-1 -: 4] == IO_NIBBLE);
    assign rd_idx = i_ram_rd_addr[AW+1:2];
    assign wr_idx = i_ram_wr_addr[AW+1:2];
    assign rd_reg = io_reg_t'(i_ram_rd_addr[3:2]);
    assign wr_reg = io_reg_t'(i_ram_wr_addr[3:2]);

    assign unused_bits = ^{i_ram_rd_mask, i_ram_rd_addr, i_ram_wr_addr};

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = !empty && i_tx_ready;
    assign push_req = i_ram_wr_en && wr_io && (wr_reg == REG_TXDATA) && i_ram_wr_mask[0];
    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = i_ram_wr_en && wr_io && (wr_reg == REG_STATUS)
                      && i_ram_wr_mask[0] && i_ram_wr_data[2];

    assign o_tx_valid = !empty;
    assign o_tx_data  = empty ? '0 : fifo_mem[rd_ptr];

    always_comb begin
        o_ram_rd_data = '0;
        if (i_ram_rd_en) begin
            if (rd_io) begin
                case (rd_reg)
                    REG_STATUS: o_ram_rd_data = {{(XLEN-3){1'b0}}, overflow, full, empty};
                    REG_CYC_LO: o_ram_rd_data = XLEN'(cycle[31:0]);
                    REG_CYC_HI: o_ram_rd_data = XLEN'(hi_shadow);
                    default:    o_ram_rd_data = '0;
                endcase
            end else begin
                o_ram_rd_data = mem[rd_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_ram_wr_en && !wr_io) begin
            for (int unsigned b = 0; b < XLEN / 8; b++) begin
                if (i_ram_wr_mask[b]) mem[wr_idx][8*b +: 8] <= i_ram_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= i_ram_wr_data[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // Setting wins over a same-cycle clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle     <= '0;
            hi_shadow <= '0;
        end else begin
            cycle <= cycle + 64'd1;
            if (i_ram_rd_en && rd_io && (rd_reg == REG_CYC_LO)) hi_shadow <= cycle[63:32];
        end
    end

endmodule

// File: tb/tb_nnrv_dmem.sv
// Directed bench for nnrv_dmem: read results and TX bytes are queued as expectations when
// the stimulus is driven and popped when the DUT presents them.
module tb_nnrv_dmem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [3:0]  rd_mask;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] rd_q [$];
    logic [7:0]  tx_q [$];
    int          model_cnt = 0;

    localparam logic [31:0] IO_TX  = 32'h1000_0000;
    localparam logic [31:0] IO_ST  = 32'h1000_0004;
    localparam logic [31:0] IO_CLO = 32'h1000_0008;
    localparam logic [31:0] IO_CHI = 32'h1000_000C;

    nnrv_dmem #(.XLEN(32), .DEPTH_WORDS(1024), .FIFO_DEPTH(8), .IO_NIBBLE(4'h1)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ram_rd_en   (rd_en),
        .i_ram_rd_addr (rd_addr),
        .i_ram_rd_mask (rd_mask),
        .o_ram_rd_data (rd_data),
        .i_ram_wr_en   (wr_en),
        .i_ram_wr_addr (wr_addr),
        .i_ram_wr_mask (wr_mask),
        .i_ram_wr_data (wr_data),
        .o_tx_valid    (tx_valid),
        .o_tx_data     (tx_data),
        .i_tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wr_set(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        rd_en = 1'b1; rd_addr = a; rd_mask = 4'hF;
        #1;
        chk(tag, rd_data, rd_q.pop_front());
    endtask

    task automatic tx_push(input logic [7:0] b);
        wr_set(IO_TX, 4'b0001, {24'h0, b});
        if (model_cnt < 8) begin
            tx_q.push_back(b);
            model_cnt++;
        end
        tick();
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, "_valid"}, {31'h0, tx_valid}, 32'h1);
            if (tx_q.size() != 0) chk({tag, "_byte"}, {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            else chk({tag, "_underrun"}, 32'h1, 32'h0);
            model_cnt--;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_mask = '0;
        wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0; tx_ready = 1'b0;

        #3;
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_txdata", {24'h0, tx_data}, 32'h0);
        rd_check("rst_status", IO_ST, 32'h1);
        rd_check("rst_cyc_lo", IO_CLO, 32'h0);
        rd_check("rst_cyc_hi", IO_CHI, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Byte-lane merge
        wr_set(32'h100, 4'b1111, 32'hDEADBEEF); tick();
        wr_set(32'h100, 4'b0001, 32'h000000AA); tick();
        rd_check("lane_merge", 32'h100, 32'hDEADBEAA);
        wr_set(32'h100, 4'b0100, 32'h00550000); tick();
        rd_check("lane2", 32'h103, 32'hDE55BEAA);
        rd_check("alias", 32'h0000_1100, 32'hDE55BEAA);
        rd_en = 1'b0; #1;
        chk("rd_idle_zero", rd_data, 32'h0);

        // IO writes never touch RAM
        wr_set(32'h8, 4'b1111, 32'h12345678); tick();
        wr_set(IO_CLO, 4'b1111, 32'hFFFFFFFF); tick();
        rd_check("io_no_ram", 32'h8, 32'h12345678);
        rd_check("txdata_rd", IO_TX, 32'h0);

        // Read-during-write returns old word
        wr_set(32'h40, 4'b1111, 32'hCAFEF00D); tick();
        wr_set(32'h40, 4'b1111, 32'h11223344);
        rd_check("rdw_old", 32'h40, 32'hCAFEF00D);
        tick();
        rd_check("rdw_new", 32'h40, 32'h11223344);

        // Overflow: 9 pushes into 8 entries with sink stalled
        for (int i = 0; i < 9; i++) tx_push(8'h41 + 8'(i));
        rd_check("ovf_status", IO_ST, 32'h6);
        tx_ready = 1'b1;
        drain(8, "drain1");
        #1;
        chk("drain1_empty", {31'h0, tx_valid}, 32'h0);
        rd_check("ovf_sticky", IO_ST, 32'h5);
        wr_set(IO_ST, 4'b0001, 32'h4); tick();
        rd_check("ovf_clear", IO_ST, 32'h1);

        // Full FIFO with simultaneous pop and push
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) tx_push(8'h61 + 8'(i));
        rd_check("full_status", IO_ST, 32'h2);
        tx_ready = 1'b1;
        wr_set(IO_TX, 4'b0001, 32'h5A);
        #1;
        chk("fullpop_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        tx_q.push_back(8'h5A);
        tick();
        drain(8, "drain2");
        rd_check("no_ovf", IO_ST, 32'h1);

        // High-half snapshot across a carry
        force dut.cycle = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cycle;
        rd_check("snap_lo", IO_CLO, 32'hFFFF_FFFE);
        tick();
        tick();
        rd_check("snap_hi", IO_CHI, 32'h0);
        rd_check("carry_lo", IO_CLO, 32'h0);
        tick();
        rd_check("carry_hi", IO_CHI, 32'h1);

        // Asynchronous reset mid-drain
        tx_ready = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 3; i++) tx_push(8'h30 + 8'(i));
        tx_ready = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, tx_valid}, 32'h0);
        chk("arst_txdata", {24'h0, tx_data}, 32'h0);
        rd_check("arst_status", IO_ST, 32'h1);
        rd_check("arst_cyc", IO_CLO, 32'h0);
        tx_q.delete();
        model_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("post_rst_valid", {31'h0, tx_valid}, 32'h0);
        rd_check("post_rst_cyc", IO_CLO, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
